debounce_scan_scheduler: RTL and testbench
==========================================

Name: debounce_scan_scheduler

Overview:
Time-multiplexed debounce engine for a bank of slow IO inputs such as switches and buttons. A round-robin scan pointer gives each channel one service slot per scan, so one shared validate/lockout sequencer runs per slot instead of one level_debouncer per pin. Per-channel state and counters are kept in register arrays. Outputs are registered debounced levels plus one-cycle change pulses, intended for feeding interrupt or event logic.

Parameters:
Channel_Count, 4, number of scanned inputs; must be >= 2.
Validation_Wait_Slots, 10, consecutive differing samples (one per visit) required to accept a new level; must be >= 1.
Lockout_Slots, 20, visits ignored after an accepted change; must be >= 1.
Counter width (derived localparam, not a parameter): $clog2(max(Validation_Wait_Slots, Lockout_Slots)+1).

Ports:
clk  input  1  system clock.
sync_rst  input  1  synchronous reset, active-low: 0 = reset.
clk_en  input  1  clock enable; all state advances only when 1.
scan_enable  input  1  1 = scan pointer advances and slots are serviced; 0 = freeze.
io_in  input  Channel_Count  raw asynchronous-source levels, already synchronized upstream.
debounced_level  output  Channel_Count  accepted level per channel.
level_change  output  Channel_Count  one-cycle pulse on the cycle after debounced_level[c] toggles.
active_channel  output  $clog2(Channel_Count)  channel serviced on the current slot.
scan_wrap  output  1  one-cycle pulse when the pointer wraps from Channel_Count-1 to 0.

Behaviour:
- Reset (sync_rst==0 at a clk edge), regardless of clk_en:
  - active_channel=0, debounced_level=0, level_change=0, scan_wrap=0.
  - All channels go to IDLE, all counters 0.
  - Reset mid-validation or mid-lockout discards the progress.
- Slot definition: a cycle with clk_en=1 and scan_enable=1 services the channel c=active_channel. On that edge:
  - io_in[c] is sampled.
  - Channel c's FSM steps.
  - The pointer advances: c+1, or 0 after Channel_Count-1.
  - Non-serviced channels hold their state.
- Per-channel FSM, stepping only on its own slot:
  - IDLE: sample==debounced_level[c] -> stay. Sample differs:
    - If Validation_Wait_Slots==1, accept immediately (see Accept).
    - Otherwise go to VALIDATE with count=1.
  - VALIDATE: sample==debounced_level[c] -> IDLE, count=0 (glitch rejected). Sample differs:
    - count+1; when count+1==Validation_Wait_Slots, Accept.
  - Accept: on the same edge, debounced_level[c] toggles, state -> LOCKOUT, count=0.
  - LOCKOUT: sample ignored; count+1; when count+1==Lockout_Slots -> IDLE, count=0.
- Latency: an accepted change is visible on debounced_level[c] directly after the accepting slot's edge. level_change[c] is high for exactly one clk cycle, the cycle immediately after that edge.
- level_change and scan_wrap are cleared on every edge where they are not set, including clk_en=0 cycles, so a pulse never stretches.
- scan_wrap is set on the edge where the pointer goes from Channel_Count-1 to 0.
- clk_en=0 or scan_enable=0: the pointer, FSMs, counters and debounced_level hold. io_in is not sampled.
- Only one channel changes per cycle, so at most one level_change bit is ever set.
- Counters never exceed their limits; wrap-around of counters is unreachable.

Test Plan:
Bench configuration for all tests: Channel_Count=4, Validation_Wait_Slots=3, Lockout_Slots=2. clk_en=1 and scan_enable=1 unless stated. Slot n = n-th enabled edge after reset release; channel 1 is serviced on slots 1, 5, 9, ...

1. Reset: hold sync_rst=0 for 3 cycles with io_in=4'hF -> all outputs 0, active_channel=0. After release, active_channel steps 0,1,2,3,0 and scan_wrap pulses on the 3->0 edge.
2. Clean press: io_in[1]=1 from slot 0 -> debounced_level[1]=1 after slot 9. level_change=4'b0010 for exactly one cycle. Other bits stay 0.
3. Glitch: io_in[2]=1 at slots 2 and 6, 0 at slot 10 -> debounced_level[2] stays 0, no level_change pulse.
4. Lockout: after test 2, drop io_in[1]=0 at slot 10. Slots 13 and 17 are ignored. Validation runs at slots 21, 25, 29 -> debounced_level[1]=0 after slot 29, with one level_change pulse.
5. Gating: repeat test 2 with clk_en toggling 1,0,1,0 -> same slot-count result in double the clk cycles. The level_change pulse is still exactly one clk wide.
6. Freeze and reset mid-operation:
   - scan_enable=0 for 7 cycles mid-validation -> active_channel and counts hold, and the acceptance slot shifts by exactly those 7 cycles.
   - sync_rst=0 during VALIDATE -> after release, a full 3 fresh slots are required before acceptance.

Source files
------------

// File: rtl/debounce_scan_scheduler.sv
// rtl/debounce_scan_scheduler.sv - round-robin multi-channel debouncer with one shared validate/lockout sequencer
module debounce_scan_scheduler #(
  parameter int Channel_Count         = 4,
  parameter int Validation_Wait_Slots = 10,
  parameter int Lockout_Slots         = 20
) (
  input  logic                             clk,
  input  logic                             sync_rst,
  input  logic                             clk_en,
  input  logic                             scan_enable,
  input  logic [Channel_Count-1:0]         io_in,
  output logic [Channel_Count-1:0]         debounced_level,
  output logic [Channel_Count-1:0]         level_change,
  output logic [$clog2(Channel_Count)-1:0] active_channel,
  output logic                             scan_wrap
);

  localparam int MAX_SLOTS = (Validation_Wait_Slots > Lockout_Slots) ? Validation_Wait_Slots : Lockout_Slots;
  localparam int CNT_W     = $clog2(MAX_SLOTS + 1);
  localparam int PTR_W     = $clog2(Channel_Count);
  localparam logic [CNT_W-1:0] VAL_LIMIT  = CNT_W'(Validation_Wait_Slots);
  localparam logic [CNT_W-1:0] LOCK_LIMIT = CNT_W'(Lockout_Slots);
  localparam logic [PTR_W-1:0] LAST_CH    = PTR_W'(Channel_Count - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_VALIDATE,
    ST_LOCKOUT
  } ch_state_t;

  ch_state_t        state_q [Channel_Count];
  logic [CNT_W-1:0] cnt_q   [Channel_Count];

  ch_state_t        cur_state;
  ch_state_t        nxt_state;
  logic [CNT_W-1:0] cur_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] nxt_cnt;
  logic             sample;
  logic             cur_level;
  logic             accept;
  logic             slot;
  logic             ptr_last;

  assign slot     = clk_en && scan_enable;
  assign ptr_last = (active_channel == LAST_CH);

  // Only the channel under the scan pointer is evaluated; everything else is held in the arrays.
  always_comb begin
    cur_state = state_q[active_channel];
    cur_cnt   = cnt_q[active_channel];
    cnt_inc   = cur_cnt + CNT_W'(1);
    sample    = io_in[active_channel];
    cur_level = debounced_level[active_channel];
    nxt_state = cur_state;
    nxt_cnt   = cur_cnt;
    accept    = 1'b0;
    case (cur_state)
      ST_IDLE: begin
        if (sample != cur_level) begin
          if (Validation_Wait_Slots == 1) begin
            accept    = 1'b1;
            nxt_state = ST_LOCKOUT;
            nxt_cnt   = '0;
          end else begin
            nxt_state = ST_VALIDATE;
            nxt_cnt   = CNT_W'(1);
          end
        end
      end
      ST_VALIDATE: begin
        if (sample == cur_level) begin
          nxt_state = ST_IDLE;
          nxt_cnt   = '0;
        end else if (cnt_inc == VAL_LIMIT) begin
          accept    = 1'b1;
          nxt_state = ST_LOCKOUT;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt_inc;
        end
      end
      ST_LOCKOUT: begin
        if (cnt_inc == LOCK_LIMIT) begin
          nxt_state = ST_IDLE;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt_inc;
        end
      end
      default: begin
        nxt_state = ST_IDLE;
        nxt_cnt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!sync_rst) begin
      for (int i = 0; i < Channel_Count; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
      debounced_level <= '0;
      level_change    <= '0;
      active_channel  <= '0;
      scan_wrap       <= 1'b0;
    end else begin
      // Pulses drop on every edge they are not re-set, enabled or not.
      level_change <= '0;
      scan_wrap    <= 1'b0;
      if (slot) begin
        state_q[active_channel] <= nxt_state;
        cnt_q[active_channel]   <= nxt_cnt;
        if (accept) begin
          debounced_level[active_channel] <= ~cur_level;
          level_change[active_channel]    <= 1'b1;
        end
        active_channel <= ptr_last ? '0 : active_channel + PTR_W'(1);
        scan_wrap      <= ptr_last;
      end
    end
  end

endmodule

// File: tb/tb_debounce_scan_scheduler.sv
// tb/tb_debounce_scan_scheduler.sv - scoreboard bench for debounce_scan_scheduler against a slot-level reference model
module tb_debounce_scan_scheduler;

  localparam int NCH = 4;
  localparam int VWS = 3;
  localparam int LS  = 2;

  logic       clk = 1'b0;
  logic       sync_rst = 1'b0;
  logic       clk_en = 1'b0;
  logic       scan_enable = 1'b0;
  logic [3:0] io_in = 4'h0;
  logic [3:0] debounced_level;
  logic [3:0] level_change;
  logic [1:0] active_channel;
  logic       scan_wrap;

  debounce_scan_scheduler #(
    .Channel_Count(NCH),
    .Validation_Wait_Slots(VWS),
    .Lockout_Slots(LS)
  ) dut (
    .clk(clk),
    .sync_rst(sync_rst),
    .clk_en(clk_en),
    .scan_enable(scan_enable),
    .io_in(io_in),
    .debounced_level(debounced_level),
    .level_change(level_change),
    .active_channel(active_channel),
    .scan_wrap(scan_wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [1:0] ac;
    logic [3:0] lvl;
    logic [3:0] chg;
    logic       wrap;
  } exp_t;

  exp_t       exp_q[$];
  int         plog_idx[$];
  logic [3:0] plog_bits[$];
  int         checks = 0;
  int         errors = 0;
  int         tick_cnt = 0;

  // Reference: per channel, accepted level, length of the current run of differing samples, and visits left to ignore.
  int m_level[NCH];
  int m_run[NCH];
  int m_lock[NCH];
  int m_ptr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic model_step(input logic rst, input logic en, input logic sen, input logic [3:0] io);
    exp_t e;
    e.idx  = tick_cnt;
    e.chg  = '0;
    e.wrap = 1'b0;
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_level[i] = 0;
        m_run[i]   = 0;
        m_lock[i]  = 0;
      end
      m_ptr = 0;
    end else if (en && sen) begin
      int c;
      c = m_ptr;
      if (m_lock[c] > 0) begin
        m_lock[c]--;
      end else if (int'(io[c]) != m_level[c]) begin
        m_run[c]++;
        if (m_run[c] == VWS) begin
          m_level[c] = 1 - m_level[c];
          m_run[c]   = 0;
          m_lock[c]  = LS;
          e.chg[c]   = 1'b1;
        end
      end else begin
        m_run[c] = 0;
      end
      m_ptr  = (c + 1) % NCH;
      e.wrap = (c == NCH - 1);
    end
    e.ac = 2'(m_ptr);
    for (int i = 0; i < NCH; i++) e.lvl[i] = m_level[i][0];
    exp_q.push_back(e);
  endtask

  task automatic tick(input logic rst, input logic en, input logic sen, input logic [3:0] io);
    @(negedge clk);
    sync_rst    = rst;
    clk_en      = en;
    scan_enable = sen;
    io_in       = io;
    model_step(rst, en, sen, io);
    tick_cnt++;
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic check_pulses(input string name, input int n, input int i0, input logic [3:0] b0,
                              input int i1, input logic [3:0] b1);
    chk({name, "_count"}, plog_idx.size(), n);
    if (n >= 1 && plog_idx.size() >= 1) begin
      chk({name, "_idx0"}, plog_idx[0], i0);
      chk({name, "_bits0"}, {28'h0, plog_bits[0]}, {28'h0, b0});
    end
    if (n >= 2 && plog_idx.size() >= 2) begin
      chk({name, "_idx1"}, plog_idx[1], i1);
      chk({name, "_bits1"}, {28'h0, plog_bits[1]}, {28'h0, b1});
    end
    plog_idx.delete();
    plog_bits.delete();
  endtask

  initial begin
    forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("active_channel", {30'h0, active_channel}, {30'h0, e.ac});
        chk("debounced_level", {28'h0, debounced_level}, {28'h0, e.lvl});
        chk("level_change", {28'h0, level_change}, {28'h0, e.chg});
        chk("scan_wrap", {31'h0, scan_wrap}, {31'h0, e.wrap});
        if (level_change != 4'h0) begin
          plog_idx.push_back(e.idx);
          plog_bits.push_back(level_change);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base;
    logic [3:0] io;
    logic [3:0] base_io;

    // Reset with all inputs high, then press on ch1, glitch on ch2, release ch1 into lockout.
    repeat (3) tick(1'b0, 1'b1, 1'b1, 4'hF);
    settle();
    plog_idx.delete();
    plog_bits.delete();
    base = tick_cnt;
    for (int s = 0; s < 36; s++) begin
      io = 4'h0;
      io[1] = (s < 10);
      io[2] = (s >= 2 && s < 10);
      tick(1'b1, 1'b1, 1'b1, io);
    end
    settle();
    check_pulses("press_lockout", 2, base + 9, 4'b0010, base + 29, 4'b0010);

    // Clock-enable gating doubles wall time for the same slot count.
    repeat (2) tick(1'b0, 1'b1, 1'b1, 4'h0);
    base = tick_cnt;
    for (int k = 0; k < 24; k++) tick(1'b1, (k % 2) == 0, 1'b1, 4'b0010);
    settle();
    check_pulses("gated_press", 1, base + 18, 4'b0010, 0, 4'h0);

    // Seven frozen cycles mid-validation shift acceptance by seven.
    repeat (2) tick(1'b0, 1'b1, 1'b1, 4'h0);
    base = tick_cnt;
    for (int k = 0; k < 6; k++) tick(1'b1, 1'b1, 1'b1, 4'b0010);
    repeat (7) tick(1'b1, 1'b1, 1'b0, 4'b0010);
    for (int k = 0; k < 10; k++) tick(1'b1, 1'b1, 1'b1, 4'b0010);
    settle();
    check_pulses("frozen_press", 1, base + 16, 4'b0010, 0, 4'h0);

    // Reset during validation discards progress.
    repeat (2) tick(1'b0, 1'b1, 1'b1, 4'h0);
    for (int k = 0; k < 6; k++) tick(1'b1, 1'b1, 1'b1, 4'b0010);
    settle();
    check_pulses("pre_reset", 0, 0, 4'h0, 0, 4'h0);
    tick(1'b0, 1'b1, 1'b1, 4'b0010);
    base = tick_cnt;
    for (int k = 0; k < 12; k++) tick(1'b1, 1'b1, 1'b1, 4'b0010);
    settle();
    check_pulses("post_reset", 1, base + 9, 4'b0010, 0, 4'h0);

    // Randomized traffic checked against the reference model each cycle.
    base_io = 4'h0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 29) == 0) base_io[$urandom_range(0, 3)] ^= 1'b1;
      io = base_io;
      if ($urandom_range(0, 14) == 0) io[$urandom_range(0, 3)] ^= 1'b1;
      tick($urandom_range(0, 499) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, io);
    end
    settle();
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
